// File: rtl/ppi_io_master_if.sv
// Host request and PPI bus signal bundle for the Z80-style I/O cycle initiator.
// The master modport is the initiator's view; slave is the host/responder side.
interface ppi_io_master_if;
    logic       req_i;
    logic       we_i;
    logic [1:0] addr_i;
    logic [7:0] wdata_i;
    logic       busy_o;
    logic       done_o;
    logic [7:0] rdata_o;
    logic       nCS_o;
    logic       a0_o;
    logic       a1_o;
    logic       nIORD_o;
    logic       nIOWR_o;
    logic [7:0] d_o;
    logic       d_oe_o;
    logic [7:0] d_i;

    modport master (
        input  req_i, we_i, addr_i, wdata_i, d_i,
        output busy_o, done_o, rdata_o, nCS_o, a0_o, a1_o,
               nIORD_o, nIOWR_o, d_o, d_oe_o
    );

    modport slave (
        output req_i, we_i, addr_i, wdata_i, d_i,
        input  busy_o, done_o, rdata_o, nCS_o, a0_o, a1_o,
               nIORD_o, nIOWR_o, d_o, d_oe_o
    );
endinterface

// File: rtl/ppi_io_master.sv
// Z80-style I/O cycle initiator toward an 8255 PPI: runs one timed
// setup/strobe/hold bus cycle per accepted host request.
module ppi_io_master #(
    parameter int unsigned SETUP_CYC  = 32'd1,
    parameter int unsigned STROBE_CYC = 32'd2,
    parameter int unsigned HOLD_CYC   = 32'd1
) (
    input  logic clk_i,
    input  logic nreset_i,
    ppi_io_master_if.master bus
);

    localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 32'd1);
    localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 32'd1);
    localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 32'd1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    logic [1:0] rst_sync_q;
    logic       rst_n_s;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       we_q, we_d;
    logic [1:0] addr_q, addr_d;
    logic [7:0] dout_q, dout_d;
    logic       doe_q, doe_d;
    logic       ncs_q, ncs_d;
    logic       nrd_q, nrd_d;
    logic       nwr_q, nwr_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [7:0] rdata_q, rdata_d;

    // Reset synchronizer: assertion reaches the datapath at once, release is clocked.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n_s = rst_sync_q[1];

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 2'b00;
            dout_q  <= 8'h00;
            doe_q   <= 1'b0;
            ncs_q   <= 1'b1;
            nrd_q   <= 1'b1;
            nwr_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rdata_q <= 8'hFF;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            doe_q   <= doe_d;
            ncs_q   <= ncs_d;
            nrd_q   <= nrd_d;
            nwr_q   <= nwr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
        end
    end

    // Phase sequencing; every register value is decided one edge ahead so the pins stay glitch-free.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        dout_d  = dout_q;
        doe_d   = doe_q;
        ncs_d   = ncs_q;
        nrd_d   = nrd_q;
        nwr_d   = nwr_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        rdata_d = rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_i) begin
                    we_d    = bus.we_i;
                    addr_d  = bus.addr_i;
                    dout_d  = bus.wdata_i;
                    doe_d   = bus.we_i;
                    ncs_d   = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = SETUP_LD;
                    state_d = ST_SETUP;
                end else begin
                    busy_d  = 1'b0;
                end
            end
            ST_SETUP: begin
                if (cnt_q == 4'd0) begin
                    cnt_d   = STROBE_LD;
                    state_d = ST_STROBE;
                    if (we_q) begin
                        nwr_d = 1'b0;
                    end else begin
                        nrd_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_STROBE: begin
                if (cnt_q == 4'd0) begin
                    nrd_d   = 1'b1;
                    nwr_d   = 1'b1;
                    cnt_d   = HOLD_LD;
                    state_d = ST_HOLD;
                    // Sample on the last low-strobe edge, where the responder's registered data is valid.
                    if (!we_q) begin
                        rdata_d = bus.d_i;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == 4'd0) begin
                    ncs_d   = 1'b1;
                    doe_d   = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                ncs_d   = 1'b1;
                nrd_d   = 1'b1;
                nwr_d   = 1'b1;
                doe_d   = 1'b0;
                busy_d  = 1'b0;
                cnt_d   = 4'd0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.busy_o  = busy_q;
    assign bus.done_o  = done_q;
    assign bus.rdata_o = rdata_q;
    assign bus.nCS_o   = ncs_q;
    assign bus.a0_o    = addr_q[0];
    assign bus.a1_o    = addr_q[1];
    assign bus.nIORD_o = nrd_q;
    assign bus.nIOWR_o = nwr_q;
    assign bus.d_o     = dout_q;
    assign bus.d_oe_o  = doe_q;

endmodule
